// File: rtl/bank_htu_req_arb_if.sv
// Requester-side valid/ready bundle for the bank HTU request arbiter.
// Requester i owns bit i of valid/ready and address bits [32*i+31:32*i].
`timescale 1ns/1ps
interface bank_htu_req_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_REQ*32-1:0] req_addr_i;

  modport master (
    output req_valid_i,
    output req_addr_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_addr_i,
    output req_ready_o
  );
endinterface

// File: rtl/bank_htu_req_arb.sv
// Round-robin HTU lookup arbiter with in-flight pipe and response tagging.
// Define BANK_HTU_ARB_SET_HAZARD_EN to block same-set lookups in flight.
`timescale 1ns/1ps
module bank_htu_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bank_htu_req_arb_if.slave  req,
  input  logic               htu_stall_i,
  output logic               htu_valid_o,
  output logic [3:0]         htu_set_o,
  output logic [31:10]       htu_tag_o,
  output logic               htu_offset_o,
  input  logic               htu_rsp_valid_i,
  input  logic               htu_rsp_hit_i,
  input  logic [1:0]         htu_rsp_status_i,
  output logic               rsp_valid_o,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic               rsp_hit_o,
  output logic [1:0]         rsp_status_o,
  output logic               err_o
);

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LAT:0]       vld_q, vld_d;
  logic [ID_W-1:0]    id_q [LAT+1];
  logic [3:0]         set0_q;
  logic [31:10]       tag0_q;
  logic               off0_q;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] hazard;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               hs;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        win_addr;
  logic [ID_W:0]      scan;
  logic [ID_W-1:0]    idx;
  logic               unused_addr;

`ifdef BANK_HTU_ARB_SET_HAZARD_EN
  // Set history for entries 1..LAT; entry 0 set lives in set0_q.
  logic [3:0] set_q [1:LAT];

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vld_q[0] &&
          req.req_addr_i[32*i+6 +: 4] == set0_q)
        hazard[i] = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
        if (vld_q[k] &&
            req.req_addr_i[32*i+6 +: 4] == set_q[k])
          hazard[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 1; k <= LAT; k++)
        set_q[k] <= '0;
    end else begin
      set_q[1] <= set0_q;
      for (int k = 2; k <= LAT; k++)
        set_q[k] <= set_q[k-1];
    end
  end
`else
  assign hazard = '0;
`endif

  assign elig = req.req_valid_i & ~hazard &
                {NUM_REQ{~htu_stall_i & ~rst_i}};

  // First eligible requester at or after rr_ptr wins.
  always_comb begin
    grant    = '0;
    win_id   = '0;
    win_addr = '0;
    hs       = 1'b0;
    scan     = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_REQ))
        scan = scan - (ID_W+1)'(NUM_REQ);
      idx = scan[ID_W-1:0];
      if (!hs && elig[idx]) begin
        hs         = 1'b1;
        grant[idx] = 1'b1;
        win_id     = idx;
        win_addr   = req.req_addr_i[32*idx +: 32];
      end
    end
  end

  assign req.req_ready_o = grant;
  assign unused_addr     = ^win_addr[4:0];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      if (win_id == ID_W'(NUM_REQ-1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = win_id + 1'b1;
    end
  end

  if (LAT > 1) begin : g_shift
    assign vld_d = {vld_q[LAT-1:0], hs};
  end else begin : g_shift1
    assign vld_d = {vld_q[0], hs};
  end

  assign err_d = err_q | (htu_rsp_valid_i != vld_q[LAT]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      set0_q   <= '0;
      tag0_q   <= '0;
      off0_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int k = 0; k <= LAT; k++)
        id_q[k] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      set0_q   <= win_addr[9:6];
      tag0_q   <= win_addr[31:10];
      off0_q   <= win_addr[5];
      err_q    <= err_d;
      id_q[0]  <= win_id;
      for (int k = 1; k <= LAT; k++)
        id_q[k] <= id_q[k-1];
    end
  end

  assign htu_valid_o  = vld_q[0];
  assign htu_set_o    = set0_q;
  assign htu_tag_o    = tag0_q;
  assign htu_offset_o = off0_q;

  assign rsp_valid_o  = htu_rsp_valid_i & vld_q[LAT];
  assign rsp_id_o     = id_q[LAT];
  assign rsp_hit_o    = rsp_valid_o & htu_rsp_hit_i;
  assign rsp_status_o = {2{rsp_valid_o}} & htu_rsp_status_i;

  // Mismatch shows the same cycle; held off while reset is asserted.
  assign err_o = ~rst_i & err_d;

endmodule

// File: tb/tb_bank_htu_req_arb.sv
// Scoreboard bench for bank_htu_req_arb (NUM_REQ=4, LAT=2).
// Directed requests push expected grants/issues/responses into queues.
`timescale 1ns/1ps
module tb_bank_htu_req_arb;
  localparam int NR  = 4;
  localparam int LAT = 2;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bank_htu_req_arb_if #(.NUM_REQ(NR)) rif ();

  logic           htu_stall = 1'b0;
  logic           htu_valid;
  logic [3:0]     htu_set;
  logic [31:10]   htu_tag;
  logic           htu_off;
  wire            rsp_v_in;
  wire            rsp_hit_in;
  wire  [1:0]     rsp_st_in;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic           rsp_hit;
  logic [1:0]     rsp_st;
  logic           err;

  bank_htu_req_arb #(.NUM_REQ(NR), .LAT(LAT)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req              (rif),
    .htu_stall_i      (htu_stall),
    .htu_valid_o      (htu_valid),
    .htu_set_o        (htu_set),
    .htu_tag_o        (htu_tag),
    .htu_offset_o     (htu_off),
    .htu_rsp_valid_i  (rsp_v_in),
    .htu_rsp_hit_i    (rsp_hit_in),
    .htu_rsp_status_i (rsp_st_in),
    .rsp_valid_o      (rsp_valid),
    .rsp_id_o         (rsp_id),
    .rsp_hit_o        (rsp_hit),
    .rsp_status_o     (rsp_st),
    .err_o            (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req_v);
    end
  endtask

  logic [31:0] rq [NR][$];
  int          exp_gnt [$];
  logic [26:0] exp_iss [$];
  logic [4:0]  exp_rsp [$];

  function automatic logic [31:0] mk(int r, int s);
    logic [31:0] a;
    logic [3:0]  rv;
    logic [3:0]  sv;
    rv = 4'(r);
    sv = 4'(s);
    a[31:10] = 22'(32'h1A2B0 + r * 64 + s * 3);
    a[9:6]   = sv;
    a[5]     = rv[0] ^ sv[1];
    a[4:0]   = 5'(r + 3);
    return a;
  endfunction

  // HTU model answers hit=set[0], status=set[2:1].
  task automatic req(input int r, input int s,
                     input bit iss, input bit rsp);
    logic [31:0] a;
    logic [3:0]  sv;
    a  = mk(r, s);
    sv = 4'(s);
    rq[r].push_back(a);
    exp_gnt.push_back(r);
    if (iss) exp_iss.push_back({a[31:10], sv, a[5]});
    if (rsp) exp_rsp.push_back({2'(r), sv[0], sv[2:1]});
  endtask

  function automatic int pending();
    int n;
    n = exp_gnt.size() + exp_iss.size() + exp_rsp.size();
    for (int i = 0; i < NR; i++) n += rq[i].size();
    return n;
  endfunction

  task automatic drain();
    for (int c = 0; c < 50 && pending() != 0; c++)
      @(negedge clk);
    chk("drain_pending", 32'(pending()), 0);
  endtask

  // Requester driver: pop after handshake, present next request.
  initial begin
    logic [NR-1:0] hs;
    rif.req_valid_i = '0;
    rif.req_addr_i  = '0;
    forever begin
      @(negedge clk);
      hs = rif.req_valid_i & rif.req_ready_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i]) void'(rq[i].pop_front());
        rif.req_valid_i[i] = (rq[i].size() != 0);
        rif.req_addr_i[32*i +: 32] =
          (rq[i].size() != 0) ? rq[i][0] : 32'h0;
      end
    end
  end

  // HTU model: respond LAT cycles after each issue.
  bit         auto_rsp = 1'b1;
  logic       man_v    = 1'b0;
  logic       m_v      = 1'b0;
  logic       m_hit    = 1'b0;
  logic [1:0] m_st     = 2'b0;
  logic [LAT:0] hv     = '0;
  logic [3:0] hset [LAT+1];

  assign rsp_v_in   = auto_rsp ? m_v : man_v;
  assign rsp_hit_in = auto_rsp ? m_hit : 1'b0;
  assign rsp_st_in  = auto_rsp ? m_st : 2'b0;

  initial begin
    for (int k = 0; k <= LAT; k++) hset[k] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = LAT; k > 0; k--) begin
        hv[k]   = hv[k-1];
        hset[k] = hset[k-1];
      end
      hv[0]   = htu_valid;
      hset[0] = htu_set;
      m_v     = hv[LAT];
      m_hit   = hv[LAT] & hset[LAT][0];
      m_st    = hv[LAT] ? hset[LAT][2:1] : 2'b0;
    end
  end

  // Monitor: pop and compare whenever the DUT presents an output.
  always @(negedge clk) begin
    if (|(rif.req_valid_i & rif.req_ready_o)) begin
      if (exp_gnt.size() == 0)
        chk("gnt_unexpected", 32'(rif.req_ready_o), 0);
      else
        chk("gnt", 32'(rif.req_ready_o),
            32'(1) << exp_gnt.pop_front());
    end
    if (htu_valid === 1'b1) begin
      if (exp_iss.size() == 0)
        chk("iss_unexpected", 32'(htu_valid), 0);
      else
        chk("iss", 32'({htu_tag, htu_set, htu_off}),
            32'(exp_iss.pop_front()));
    end
    if (rsp_valid === 1'b1) begin
      if (exp_rsp.size() == 0)
        chk("rsp_unexpected", 32'(rsp_valid), 0);
      else
        chk("rsp", 32'({rsp_id, rsp_hit, rsp_st}),
            32'(exp_rsp.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hz;
    repeat (2) @(negedge clk);
    chk("rst_htu_valid", 32'(htu_valid), 0);
    chk("rst_ready", 32'(rif.req_ready_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Round robin, distinct sets 0..7.
    @(negedge clk);
    for (int r = 0; r < NR; r++) req(r, r, 1, 1);
    for (int r = 0; r < NR; r++) req(r, r + 4, 1, 1);
    @(negedge clk);
    chk("rr_first_ready", 32'(rif.req_ready_o), 32'h1);
    chk("rr_first_htu_valid", 32'(htu_valid), 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("rr_htu_valid", 32'(htu_valid), 1);
    end
    drain();
    chk("rr_err", 32'(err), 0);

    // Same-set hazard on set 5.
    req(0, 5, 1, 1);
    @(negedge clk);
    chk("haz_ready_T", 32'(rif.req_ready_o), 32'h1);
    req(1, 5, 1, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
`ifdef BANK_HTU_ARB_SET_HAZARD_EN
      hz = (c == 4) ? 4'h2 : 4'h0;
`else
      hz = (c == 1) ? 4'h2 : 4'h0;
`endif
      chk("haz_ready", 32'(rif.req_ready_o), 32'(hz));
    end
    drain();
    chk("haz_err", 32'(err), 0);

    // Stall with requesters 2 and 3 pending; rr_ptr is 2.
    req(2, 8, 1, 1);
    req(3, 9, 1, 1);
    @(posedge clk); #1 htu_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_ready", 32'(rif.req_ready_o), 0);
    end
    @(posedge clk); #1 htu_stall = 1'b0;
    @(negedge clk);
    chk("stall_release_ready", 32'(rif.req_ready_o), 32'h4);
    drain();

    // Response routing: requester 3, set 5 -> hit 1, status 10.
    req(3, 5, 1, 1);
    @(negedge clk);
    chk("route_ready", 32'(rif.req_ready_o), 32'h8);
    repeat (3) @(negedge clk);
    chk("route_rsp_valid", 32'(rsp_valid), 1);
    chk("route_rsp_id", 32'(rsp_id), 3);
    chk("route_rsp_hit", 32'(rsp_hit), 1);
    chk("route_rsp_status", 32'(rsp_st), 32'h2);
    drain();
    chk("route_err", 32'(err), 0);

    // Protocol error with empty pipe.
    auto_rsp = 1'b0;
    @(posedge clk); #1 man_v = 1'b1;
    @(negedge clk);
    chk("perr_err", 32'(err), 1);
    chk("perr_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1 man_v = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("perr_sticky", 32'(err), 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("perr_rst_err", 32'(err), 0);
    @(posedge clk); #1 rst = 1'b0;
    auto_rsp = 1'b1;
    @(negedge clk);

    // Reset mid-flight: grants at T, T+1, reset at T+2.
    req(0, 10, 1, 0);
    req(1, 11, 0, 0);
    @(negedge clk);
    chk("mid_ready_T", 32'(rif.req_ready_o), 32'h1);
    @(negedge clk);
    chk("mid_ready_T1", 32'(rif.req_ready_o), 32'h2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_htu_valid", 32'(htu_valid), 0);
    chk("mid_ready", 32'(rif.req_ready_o), 0);
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_err", 32'(err), 0);
    chk("mid_htu_set", 32'(htu_set), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_stray_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_stray_err", 32'(err), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_err_cleared", 32'(err), 0);

    // rr_ptr back at 0: requester 1 beats requester 3.
    req(1, 12, 1, 1);
    req(3, 13, 1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_ptr_ready", 32'(rif.req_ready_o), 32'h8);
    drain();
    chk("final_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_htu_req_arb.md
# bank_htu_req_arb

Round-robin request arbiter and sequencer in front of a bank's hit-test unit (HTU). It accepts lookup requests from `NUM_REQ` requesters over valid/ready handshakes and issues one lookup per cycle to the HTU set-status logic. It tracks in-flight lookups so that two lookups to the same set never overlap, and tags each HTU response with the originating requester ID. It sits between the bank's request crossbar and the per-set HTU status blocks.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `LAT`, default 2: fixed HTU response latency in cycles, measured from `htu_valid_o`; legal range 1..4.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  `NUM_REQ`  per-requester request valid.
- `req_ready_o`  out  `NUM_REQ`  per-requester grant; at most one bit high.
- `req_addr_i`  in  `NUM_REQ*32`  flattened request addresses; requester i uses bits `[32*i+31:32*i]`.
- `htu_stall_i`  in  1  HTU busy (refill in progress); blocks new grants.
- `htu_valid_o`  out  1  lookup issue strobe.
- `htu_set_o`  out  4  set index, from address bits `[9:6]`.
- `htu_tag_o`  out  `[31:10]`  lookup tag, from address bits `[31:10]`.
- `htu_offset_o`  out  1  half-line offset, from address bit `[5]`.
- `htu_rsp_valid_i`  in  1  HTU response valid.
- `htu_rsp_hit_i`  in  1  HTU hit flag.
- `htu_rsp_status_i`  in  2  status of the hit offset.
- `rsp_valid_o`  out  1  response to requesters.
- `rsp_id_o`  out  `ID_W`  requester ID the response belongs to.
- `rsp_hit_o`  out  1  forwarded hit flag.
- `rsp_status_o`  out  2  forwarded status.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Request protocol.** Requester i holds `req_valid_i[i]` and its address stable until `req_ready_o[i]` is high. A handshake occurs when valid and ready are both high in the same cycle.
- **Eligibility.** Requester i is eligible when all of the following hold: `req_valid_i[i]` is high; `htu_stall_i` is low; and its set index matches no valid entry of the in-flight pipe (hazard check, see Configuration).
- **Arbitration.** `rr_ptr` (reset 0) selects the highest-priority requester. The winner is the first eligible requester scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`. `req_ready_o` is the one-hot winner, or zero if no requester is eligible. After a handshake by requester i, `rr_ptr` becomes `(i+1) mod NUM_REQ`; otherwise `rr_ptr` holds.
- **In-flight pipe.** The pipe has `LAT+1` entries, each holding `{valid, id, set}`.
  - Entry 0 is the issue register and drives `htu_valid_o`, `htu_set_o`, `htu_tag_o` and `htu_offset_o`. The tag and offset are registered alongside entry 0.
  - Entries shift one position every cycle and never stall.
  - Entry `LAT` is the tail; it lines up with the expected HTU response.
- **Responses.**
  - `rsp_valid_o = htu_rsp_valid_i & tail.valid`.
  - `rsp_id_o = tail.id`.
  - `rsp_hit_o` and `rsp_status_o` pass through combinationally from the HTU.
  - When `rsp_valid_o` is low, `rsp_hit_o` and `rsp_status_o` are forced to 0.
- **Error.** `err_o` sets on any cycle where `htu_rsp_valid_i != tail.valid`. It stays high until reset.
- **Reset** (also when asserted mid-operation):
  - All pipe entries are invalidated, `rr_ptr` = 0 and `err_o` = 0.
  - All outputs go to 0.
  - In-flight lookups are discarded; no response is emitted for them after reset is released.

## Timing
- A handshake in cycle T gives `htu_valid_o` = 1 in T+1. The HTU response is expected in T+1+LAT, and `rsp_valid_o` is asserted in that same cycle (zero added latency).
- The grant path is combinational from `req_valid_i`, `htu_stall_i` and pipe state. There is no combinational path from `htu_rsp_*` to `req_ready_o`.
- Throughput is one grant per cycle when the requests target distinct sets.
- With the hazard check compiled in, a same-set request is blocked from cycle T through T+1+LAT inclusive, because the retiring tail entry still blocks. The earliest same-set re-grant is therefore T+2+LAT.
- `htu_stall_i` blocks grants only. An entry already in the issue register is presented regardless of `htu_stall_i`, and the HTU must accept it.
- A requester that is blocked (by hazard or stall) keeps its priority, because `rr_ptr` does not advance.

## Configuration
- Macro: `BANK_HTU_ARB_SET_HAZARD_EN`.
- **Defined:** the set-index hazard check described above is active.
- **Undefined:** the hazard compare logic is removed. Eligibility is `req_valid_i[i] & ~htu_stall_i`, and back-to-back same-set lookups are issued every cycle. The pipe still carries `id` for response routing; the `set` field may be optimized away.

## Test plan
All scenarios use `NUM_REQ`=4 and `LAT`=2.
- **Round-robin fairness.** All 4 requesters valid continuously, addresses in sets 0..3, `rr_ptr`=0 → grants go 0,1,2,3,0 on consecutive cycles; `htu_valid_o` is high every cycle from the second cycle.
- **Set hazard.** Requester 0 wants set 5 and is granted at T. Requester 1 wants set 5 from T+1 → `req_ready_o[1]` stays 0 through T+3 and goes high at T+4. Without the macro, requester 1 is granted at T+1.
- **Stall.** `htu_stall_i`=1 for 3 cycles while requesters 2 and 3 are valid → `req_ready_o`=0 throughout. The cycle after the stall drops, requester 2 is granted (with `rr_ptr`=2).
- **Response routing.** Requester 3 is granted at T; the HTU returns hit=1, status=2'b10 at T+3 → `rsp_valid_o`=1, `rsp_id_o`=3, `rsp_hit_o`=1, `rsp_status_o`=2'b10.
- **Protocol error.** `htu_rsp_valid_i`=1 with the pipe empty → `err_o`=1 from that cycle and stays 1 until `rst_i`, while `rsp_valid_o` stays 0.
- **Reset mid-flight.** Grants at T and T+1, then `rst_i` pulses at T+2 → all outputs are 0 and `rr_ptr`=0. An HTU response driven at T+3 gives `rsp_valid_o`=0 and sets `err_o`.
